// File: rtl/cpu_int_pkg.sv
// Shared types and defaults for the CPU interrupt controller slice.
package cpu_int_pkg;

  localparam int          NUM_IRQ_DEF  = 4;
  localparam logic [15:0] VEC_BASE_DEF = 16'h0010;
  localparam int          MAX_IRQ      = 8;
  localparam int          ID_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  function automatic logic [MAX_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot = 8'd1 << id;
  endfunction

  // Vector slots are two bytes apart, starting at base.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [ID_W-1:0] id);
    vec_addr = base + {12'd0, id, 1'b0};
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority find-first-set: the lowest-index asserted request wins.
module irq_priority_enc
  import cpu_int_pkg::*;
#(
  parameter int N = NUM_IRQ_DEF
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    id_o    = 3'd0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = i[ID_W-1:0];
        valid_o = 1'b1;
      end else begin
        id_o    = id_o;
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, enable-gated, fixed-priority interrupt controller with a
// single-level IDLE/REQ/SERVICE handshake toward the core.
module interrupt_controller
  import cpu_int_pkg::*;
#(
  parameter int          NUM_IRQ  = NUM_IRQ_DEF,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_masked,
  input  logic               en_load,
  input  logic [15:0]        en_data,
  input  logic               irq_ack,
  input  logic               iret,
  output logic               irq_req,
  output logic [15:0]        irq_vector,
  output logic               mask_int,
  output logic               unmask_int,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  logic [NUM_IRQ-1:0] irq_smp_q;
  logic [NUM_IRQ-1:0] irq_hist_q;
  logic [1:0]         arm_q;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               irq_req_q, irq_req_d;
  logic [15:0]        vec_q, vec_d;
  logic               mask_q, mask_d;
  logic               unmask_q, unmask_d;

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [MAX_IRQ-1:0] id_oh_s;
  logic [ID_W-1:0]    win_id_s;
  logic               win_valid_s;
  logic               en_id_s;

  // arm_q holds off edge detection until the history register carries two
  // real post-reset samples, so a line held high through reset is not an edge.
  assign rise_s     = irq_smp_q & ~irq_hist_q & {NUM_IRQ{arm_q[1]}};
  assign eligible_s = pending_q & en_q;
  assign id_oh_s    = id_onehot(id_q);
  assign en_id_s    = |(en_q & id_oh_s[NUM_IRQ-1:0]);
  assign pending_d  = (pending_q & ~clr_s) | rise_s;

  irq_priority_enc #(
    .N (NUM_IRQ)
  ) u_prio (
    .req_i   (eligible_s),
    .id_o    (win_id_s),
    .valid_o (win_valid_s)
  );

  // Handshake FSM next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    irq_req_d    = irq_req_q;
    vec_d        = vec_q;
    mask_d       = 1'b0;
    unmask_d     = 1'b0;
    in_service_d = in_service_q;
    clr_s        = {NUM_IRQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s && !int_masked) begin
          state_d   = ST_REQ;
          id_d      = win_id_s;
          irq_req_d = 1'b1;
          vec_d     = vec_addr(VEC_BASE, win_id_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d      = ST_SERVICE;
          clr_s        = id_oh_s[NUM_IRQ-1:0];
          in_service_d = id_oh_s[NUM_IRQ-1:0];
          irq_req_d    = 1'b0;
          vec_d        = 16'h0000;
          mask_d       = 1'b1;
        end else if (int_masked || !en_id_s) begin
          state_d   = ST_IDLE;
          irq_req_d = 1'b0;
          vec_d     = 16'h0000;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (iret) begin
          state_d      = ST_IDLE;
          in_service_d = {NUM_IRQ{1'b0}};
          unmask_d     = 1'b1;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        irq_req_d    = 1'b0;
        vec_d        = 16'h0000;
        in_service_d = {NUM_IRQ{1'b0}};
      end
    endcase
  end

  // State, edge history, enables and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_smp_q    <= {NUM_IRQ{1'b0}};
      irq_hist_q   <= {NUM_IRQ{1'b0}};
      arm_q        <= 2'b00;
      en_q         <= {NUM_IRQ{1'b0}};
      pending_q    <= {NUM_IRQ{1'b0}};
      in_service_q <= {NUM_IRQ{1'b0}};
      state_q      <= ST_IDLE;
      id_q         <= 3'd0;
      irq_req_q    <= 1'b0;
      vec_q        <= 16'h0000;
      mask_q       <= 1'b0;
      unmask_q     <= 1'b0;
    end else begin
      irq_smp_q    <= irq_in;
      irq_hist_q   <= irq_smp_q;
      arm_q        <= {arm_q[0], 1'b1};
      en_q         <= en_load ? en_data[NUM_IRQ-1:0] : en_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
      id_q         <= id_d;
      irq_req_q    <= irq_req_d;
      vec_q        <= vec_d;
      mask_q       <= mask_d;
      unmask_q     <= unmask_d;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_vector = vec_q;
  assign mask_int   = mask_q;
  assign unmask_int = unmask_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: a vector table for the basic flows, then hand sequences
// for masking, disable-while-requesting, set-vs-ack collision and reset.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic        int_masked;
  logic        en_load;
  logic [15:0] en_data;
  logic        irq_ack;
  logic        iret;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        mask_int;
  logic        unmask_int;
  logic [3:0]  pending;
  logic [3:0]  in_service;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  irq;
    logic        msk;
    logic        ld;
    logic [15:0] ed;
    logic        ack;
    logic        iret;
    logic        e_req;
    logic [15:0] e_vec;
    logic        e_mask;
    logic        e_unmask;
    logic [3:0]  e_pend;
    logic [3:0]  e_isv;
  } vec_t;

  vec_t tbl[$];

  interrupt_controller #(
    .NUM_IRQ  (4),
    .VEC_BASE (16'h0010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .int_masked (int_masked),
    .en_load    (en_load),
    .en_data    (en_data),
    .irq_ack    (irq_ack),
    .iret       (iret),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .mask_int   (mask_int),
    .unmask_int (unmask_int),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(input logic r, input logic [3:0] i, input logic m, input logic l,
                               input logic [15:0] d, input logic a, input logic t,
                               input logic eq, input logic [15:0] ev, input logic em,
                               input logic eu, input logic [3:0] ep, input logic [3:0] ei);
    row = '{r, i, m, l, d, a, t, eq, ev, em, eu, ep, ei};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] i, input logic m, input logic l, input logic [15:0] d,
                      input logic a, input logic t);
    irq_in = i; int_masked = m; en_load = l; en_data = d; irq_ack = a; iret = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 4'h0; int_masked = 1'b0; en_load = 1'b0;
    en_data = 16'h0000; irq_ack = 1'b0; iret = 1'b0;

    // rst irq msk ld ed ack iret | req vec mask unmask pend isv
    tbl.push_back(row(1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'h0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h4, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0014, 1'b0, 1'b0, 4'h4, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b0, 4'h4, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h4));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h4));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h4));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hA, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 4'hA, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h8, 4'h2));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h8, 4'h2));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h8, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0016, 1'b0, 1'b0, 4'h8, 4'h0));
    tbl.push_back(row(1'b1, 4'hA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'h8));
    tbl.push_back(row(1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h0, 4'h0));
    tbl.push_back(row(1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0));

    for (int k = 0; k < tbl.size(); k++) begin
      rst_n = tbl[k].rst_n;
      step(tbl[k].irq, tbl[k].msk, tbl[k].ld, tbl[k].ed, tbl[k].ack, tbl[k].iret);
      chk("irq_req",    k, {15'd0, irq_req},    {15'd0, tbl[k].e_req});
      chk("irq_vector", k, irq_vector,          tbl[k].e_vec);
      chk("mask_int",   k, {15'd0, mask_int},   {15'd0, tbl[k].e_mask});
      chk("unmask_int", k, {15'd0, unmask_int}, {15'd0, tbl[k].e_unmask});
      chk("pending",    k, {12'd0, pending},    {12'd0, tbl[k].e_pend});
      chk("in_service", k, {12'd0, in_service}, {12'd0, tbl[k].e_isv});
    end

    // Global mask holds off a pending source; masking inside REQ withdraws it.
    step(4'h1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("masked_req",  100, {15'd0, irq_req}, 16'h0000);
    chk("masked_pend", 100, {12'd0, pending}, 16'h0001);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("unmasked_req", 101, {15'd0, irq_req}, 16'h0001);
    chk("unmasked_vec", 101, irq_vector,      16'h0010);
    step(4'h1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("remask_req",  102, {15'd0, irq_req}, 16'h0000);
    chk("remask_vec",  102, irq_vector,       16'h0000);
    chk("remask_pend", 102, {12'd0, pending}, 16'h0001);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("reoffer_req", 103, {15'd0, irq_req}, 16'h0001);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("mask_seq_unmask", 104, {15'd0, unmask_int}, 16'h0001);
    step(4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Disabling the offered source withdraws the request; re-enabling re-offers.
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("en_req", 110, irq_vector, 16'h0014);
    step(4'h4, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b0);
    chk("en_load_cycle_req", 111, {15'd0, irq_req}, 16'h0001);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("dis_req",  112, {15'd0, irq_req}, 16'h0000);
    chk("dis_vec",  112, irq_vector,       16'h0000);
    chk("dis_pend", 112, {12'd0, pending}, 16'h0004);
    step(4'h4, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
    chk("reen_load_req", 113, {15'd0, irq_req}, 16'h0000);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("reen_req", 114, {15'd0, irq_req}, 16'h0001);
    chk("reen_vec", 114, irq_vector,       16'h0014);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // A fresh edge on the acknowledged source in the ack cycle stays pending.
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("col_req_vec", 120, irq_vector, 16'h0010);
    step(4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("col_pend", 121, {12'd0, pending},    16'h0001);
    chk("col_isv",  121, {12'd0, in_service}, 16'h0001);
    chk("col_mask", 121, {15'd0, mask_int},   16'h0001);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("col_unmask", 122, {15'd0, unmask_int}, 16'h0001);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("col_reoffer", 123, irq_vector, 16'h0010);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset during SERVICE with a source held high across it.
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("pre_rst_isv", 130, {12'd0, in_service}, 16'h0004);
    rst_n = 1'b0;
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rst_all", 131, {irq_req, mask_int, unmask_int, 5'd0, pending, in_service}, 16'h0000);
    chk("rst_vec", 131, irq_vector, 16'h0000);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("post_rst_pend",   132 + c, {12'd0, pending},    16'h0000);
      chk("post_rst_unmask", 132 + c, {15'd0, unmask_int}, 16'h0000);
    end
    step(4'h0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_edge", 140, {12'd0, pending}, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
